button_debounce: RTL
====================

# button_debounce

Debounces a raw mechanical switch or push-button input and drives a clean, glitch-free level to the downstream edge-detector stage. The raw input is first passed through a two-flop synchronizer. A four-state FSM with a down-counter then accepts a new level only after it has been stable for a programmable number of clock cycles. The block also emits a one-cycle pulse on every accepted rising transition, for consumers that need an event rather than a level.

## Interface

Parameters:
- STABLE_CNT, default 1_000_000 — clock cycles the counter runs for acceptance (10 ms at 100 MHz); legal range 1 to 2^CNT_W.
- CNT_W, default 20 — width of the stability down-counter.

Ports:
- clk — input, 1 bit. Single clock; all state updates on its rising edge.
- reset — input, 1 bit. Synchronous, active-high.
- sw — input, 1 bit. Raw, asynchronous, bouncing switch input.
- db_level — output, 1 bit. Debounced level; feeds the downstream `level` input.
- db_tick — output, 1 bit. One-cycle pulse on each accepted 0→1 transition of db_level.
- busy — output, 1 bit. High while a candidate transition is being qualified (WAIT1 or WAIT0).

## Operation

- Synchronizer: sync1 <= sw; sw_s <= sync1. Only sw_s is used downstream.
- Counter cnt (CNT_W bits): loaded with STABLE_CNT-1 on entry to WAIT1 or WAIT0; decremented by 1 in each WAIT cycle that does not exit; never wraps.
- FSM states and transitions, evaluated at each clock edge:
  - ZERO: if sw_s=1, go to WAIT1 and load cnt; otherwise stay.
  - WAIT1: if sw_s=0, go to ZERO. Else if cnt=0, go to ONE. Else decrement cnt.
  - ONE: if sw_s=0, go to WAIT0 and load cnt; otherwise stay.
  - WAIT0: if sw_s=1, go to ONE. Else if cnt=0, go to ZERO. Else decrement cnt.
- Aborting a WAIT state never changes db_level and never pulses db_tick.
- db_level is registered, 1 in ONE and WAIT0 and 0 in ZERO and WAIT1.
- db_tick is registered, 1 for exactly the one cycle after the WAIT1→ONE transition.
- The WAIT0→ZERO transition produces no pulse.
- busy is 1 in WAIT1 and WAIT0.
- Unreachable state encodings go to ZERO on the next edge; outputs are 0 in that cycle.

## Timing

- Reset values, one edge after reset is sampled high:
  - sync1 = 0, sw_s = 0
  - state = ZERO, cnt = 0
  - db_level = 0, db_tick = 0, busy = 0
- Reset mid-operation (including from ONE or WAIT0 with db_level=1): db_level drops to 0 on the next edge with no pulse.
- After reset, a held-high sw is re-qualified normally and does produce db_tick.
- Acceptance rule: a level is accepted only if sw_s holds it on STABLE_CNT+1 consecutive edges.
- Latency, with k = first edge at which sw is sampled at its new value and held:
  - sw_s changes after edge k+1.
  - The state enters WAIT after edge k+2.
  - db_level changes after edge k+STABLE_CNT+2.
  - db_tick is high in the cycle after edge k+STABLE_CNT+2.
- A pulse or glitch on sw shorter than STABLE_CNT+1 cycles causes no output change.
- Edge case STABLE_CNT=1: WAIT exits on its first evaluated edge; latency is 3 edges.
- db_tick is never high for two consecutive cycles.
- The minimum spacing between db_tick pulses is 2·(STABLE_CNT+1) cycles.

## Test plan

All scenarios use STABLE_CNT=4 and CNT_W=3.
- Reset: hold reset for 2 cycles with sw=1, then release → db_level=0, db_tick=0 and busy=0 during reset; db_level=1 with a single db_tick after edge 6 post-release.
- Clean press: sw 0→1 sampled at edge 10 and held → busy=1 in cycles 13–16; db_level=1 and db_tick=1 after edge 16; db_tick=0 after edge 17.
- Boundary glitch: a 4-cycle high pulse on sw → db_level stays 0, no db_tick, busy returns to 0. A 5-cycle pulse → db_level rises exactly once with one db_tick, then falls 6 edges after sw returns low.
- Bounce: sw toggles every 2 cycles for 20 cycles, then holds 1 → no db_tick during bouncing; exactly one db_tick 6 edges after the final rise.
- Release bounce: from ONE, sw drops for 3 cycles, returns to 1, then drops for good → db_level stays 1 through the glitch; falls 6 edges after the final drop; no db_tick.
- Mid-qualify reset: assert reset while in WAIT0 with db_level=1 → db_level=0 on the next edge, no db_tick; after release with sw=1 held, the normal rise and one db_tick follow.

Source files
------------

// File: rtl/button_debounce.sv
// Debounces a raw switch: 2-flop synchronizer, then a level is accepted after STABLE_CNT+1 stable edges.
// Latency STABLE_CNT+2 edges from first sample to db_level; free-running, no backpressure.
module button_debounce #(
    parameter int STABLE_CNT = 1_000_000,
    parameter int CNT_W      = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic db_tick,
    output logic busy
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CNT - 1);

    logic             sync1_q, sync1_d;
    logic             sw_s_q, sw_s_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_level_q, db_level_d;
    logic             db_tick_q, db_tick_d;
    logic             busy_q, busy_d;

    always_comb begin
        sync1_d = sw;
        sw_s_d  = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ZERO: begin
                if (sw_s_q) begin
                    state_d = WAIT1;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT1: begin
                if (!sw_s_q) begin
                    state_d = ZERO;
                end else if (cnt_q == '0) begin
                    state_d = ONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ONE: begin
                if (!sw_s_q) begin
                    state_d = WAIT0;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT0: begin
                if (sw_s_q) begin
                    state_d = ONE;
                end else if (cnt_q == '0) begin
                    state_d = ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ZERO;
            end
        endcase

        // Outputs are decoded from the next state so they line up with the state register.
        db_level_d = (state_d == ONE) || (state_d == WAIT0);
        busy_d     = (state_d == WAIT1) || (state_d == WAIT0);
        db_tick_d  = (state_q == WAIT1) && (state_d == ONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sw_s_q     <= 1'b0;
            state_q    <= ZERO;
            cnt_q      <= '0;
            db_level_q <= 1'b0;
            db_tick_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sw_s_q     <= sw_s_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            db_level_q <= db_level_d;
            db_tick_q  <= db_tick_d;
            busy_q     <= busy_d;
        end
    end

    assign db_level = db_level_q;
    assign db_tick  = db_tick_q;
    assign busy     = busy_q;

endmodule
